// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory stall controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    RD_DONE = 2'd3
  } dmem_state_e;

  localparam logic [31:0] ERR_DATA        = 32'hDEADBEEF;
  localparam int          DEFAULT_TIMEOUT = 255;
  // Wide enough for the largest supported TIMEOUT (1023).
  localparam int          CTR_W           = 10;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory request; flags the cycle in
// which the count reaches TIMEOUT so the caller can abandon the request.
module bus_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         count <= '0;
    else if (clear)    count <= '0;
    else if (count_en) count <= count + CTR_W'(1);
  end

  // Fires in the wait cycle that brings the count up to TIMEOUT.
  assign expired = count_en && (count == LAST);

endmodule

// File: rtl/dmem_stall_ctrl.sv
// M-stage data-memory controller: posted writes, blocking reads, stall
// generation for the hazard unit and a per-request timeout with sticky error.
module dmem_stall_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_m,
  input  logic              dmem_write_m,
  input  logic [ADDR_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] write_data_m,
  output logic              stall_mem,
  output logic [DATA_W-1:0] read_data_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  dmem_state_e       state;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_ok;
  logic              timeout_hit;

  // Acks that arrive with no request outstanding are stray and dropped.
  assign ack_ok = mem_ack & mem_req;

  bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .count_en (mem_req & ~mem_ack),
    .clear    (~mem_req),
    .expired  (timeout_hit)
  );

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    stall_mem = 1'b0;
    case (state)
      IDLE:    stall_mem = mem_read_m;
      WR_BUSY: stall_mem = mem_read_m | dmem_write_m;
      RD_BUSY: stall_mem = 1'b1;
      RD_DONE: stall_mem = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A read wins when both strobes are set; the conflict is logged.
          if (mem_read_m) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= alu_out_m;
            state    <= RD_BUSY;
            if (dmem_write_m) bus_err <= 1'b1;
          end else if (dmem_write_m) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= alu_out_m;
            mem_wdata <= write_data_m;
            state     <= WR_BUSY;
          end
        end
        WR_BUSY: begin
          if (ack_ok || timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
            if (!ack_ok) bus_err <= 1'b1;
          end
        end
        RD_BUSY: begin
          if (ack_ok) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= RD_DONE;
          end else if (timeout_hit) begin
            rdata_q <= DATA_W'(ERR_DATA);
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= RD_DONE;
          end
        end
        RD_DONE: state <= IDLE;
      endcase
    end
  end

  assign read_data_m = rdata_q;

endmodule
